// File: rtl/risc_pkg.sv
// Shared core/memory types: data-memory access size and responder FSM states.
package risc_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } op_enum_dmem_size;

   typedef enum logic [1:0] {
      DM_IDLE,
      DM_WAIT,
      DM_RESP
   } dmem_state_e;

   // Number of bytes touched by an access; illegal encodings report 1 and are faulted elsewhere.
   function automatic logic [2:0] dmem_size_bytes(input op_enum_dmem_size size);
      case (size)
         SIZE_BYTE: return 3'd1;
         SIZE_HALF: return 3'd2;
         SIZE_WORD: return 3'd4;
         default:   return 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering for little-endian byte/half/word accesses: byte enables, write
// lane placement, misalignment detection and load extension.
module dmem_lane_align
   import risc_pkg::*;
(
   input  logic [1:0]       addr_lo,
   input  op_enum_dmem_size mem_size,
   input  logic             zero_ex,
   input  logic [31:0]      wr_data,
   input  logic [31:0]      raw_rd,
   output logic [3:0]       byte_en,
   output logic [31:0]      wr_lanes,
   output logic             misaligned,
   output logic [31:0]      ld_data
);

   logic [4:0]  shamt;
   logic [31:0] rd_shift;

   assign shamt    = {addr_lo, 3'b000};
   assign rd_shift = raw_rd >> shamt;

   always_comb begin
      byte_en    = '0;
      wr_lanes   = wr_data << shamt;
      misaligned = 1'b0;
      ld_data    = raw_rd;
      case (mem_size)
         SIZE_BYTE: begin
            byte_en = 4'b0001 << addr_lo;
            ld_data = {{24{rd_shift[7] & ~zero_ex}}, rd_shift[7:0]};
         end
         SIZE_HALF: begin
            byte_en    = 4'b0011 << addr_lo;
            misaligned = addr_lo[0];
            ld_data    = {{16{rd_shift[15] & ~zero_ex}}, rd_shift[15:0]};
         end
         SIZE_WORD: begin
            byte_en    = 4'b1111;
            misaligned = |addr_lo;
         end
         default: misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-addressed little-endian RAM behind a registered
// accept/response handshake with LATENCY wait cycles and fault reporting.
module dmem_responder
  import risc_pkg::*;
#(
  parameter int    ADDR_WIDTH = 16,
  parameter int    DEPTH      = 2**16,
  parameter int    LATENCY    = 1,
  parameter string MEM_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  req,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  op_enum_dmem_size      mem_size,
  input  logic                  zero_ex,
  input  logic [31:0]           wr_data,
  output logic                  ready,
  output logic                  rsp_valid,
  output logic [31:0]           rd_data,
  output logic                  err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [2:0] LAST_CNT = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  dmem_state_e state, state_next;
  logic [2:0]  wait_cnt;

  logic                  c_wen, c_zero_ex;
  logic [ADDR_WIDTH-1:0] c_addr;
  op_enum_dmem_size      c_size;
  logic [31:0]           c_wr_data;

  logic                  e_wen, e_zero_ex;
  logic [ADDR_WIDTH-1:0] e_addr;
  op_enum_dmem_size      e_size;
  logic [31:0]           e_wr_data;

  logic [3:0]            byte_en;
  logic [31:0]           wr_lanes, ld_data, raw_rd;
  logic                  misaligned, fault, enter_resp;
  logic [IDX_W-3:0]      word_idx;
  logic [ADDR_WIDTH:0]   size_ext, last_byte;

  logic [7:0] mem [DEPTH];

  assign ready     = (state == DM_IDLE);
  assign rsp_valid = (state == DM_RESP);

  // Live inputs while idle so a zero-latency access uses the request on its accept edge.
  assign e_wen     = ready ? wen      : c_wen;
  assign e_addr    = ready ? addr     : c_addr;
  assign e_size    = ready ? mem_size : c_size;
  assign e_zero_ex = ready ? zero_ex  : c_zero_ex;
  assign e_wr_data = ready ? wr_data  : c_wr_data;

  assign word_idx  = e_addr[IDX_W-1:2];
  assign raw_rd    = {mem[{word_idx, 2'd3}], mem[{word_idx, 2'd2}],
                      mem[{word_idx, 2'd1}], mem[{word_idx, 2'd0}]};
  assign size_ext  = (ADDR_WIDTH + 1)'(dmem_size_bytes(e_size));
  assign last_byte = {1'b0, e_addr} + size_ext - (ADDR_WIDTH + 1)'(1);
  assign fault     = misaligned | (last_byte >= DEPTH_L);

  dmem_lane_align u_align (
    .addr_lo    (e_addr[1:0]),
    .mem_size   (e_size),
    .zero_ex    (e_zero_ex),
    .wr_data    (e_wr_data),
    .raw_rd     (raw_rd),
    .byte_en    (byte_en),
    .wr_lanes   (wr_lanes),
    .misaligned (misaligned),
    .ld_data    (ld_data)
  );

  always_comb begin
    state_next = state;
    case (state)
      DM_IDLE: if (req) state_next = (LATENCY == 0) ? DM_RESP : DM_WAIT;
      DM_WAIT: if (wait_cnt == LAST_CNT) state_next = DM_RESP;
      DM_RESP: state_next = DM_IDLE;
      default: state_next = DM_IDLE;
    endcase
  end

  assign enter_resp = (state_next == DM_RESP);

  always_ff @(posedge clk) begin
    if (res) begin
      state    <= DM_IDLE;
      wait_cnt <= '0;
      rd_data  <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == DM_WAIT) ? wait_cnt + 3'd1 : 3'd0;
      err      <= enter_resp & fault;
      if (enter_resp && !e_wen) rd_data <= fault ? '0 : ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (ready && req) begin
      c_wen     <= wen;
      c_addr    <= addr;
      c_size    <= mem_size;
      c_zero_ex <= zero_ex;
      c_wr_data <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!res && enter_resp && e_wen && !fault) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[{word_idx, 2'(i)}] <= wr_lanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a flat byte-array model.
module tb_dmem_responder;
   import risc_pkg::*;

   localparam int LAT   = 2;
   localparam int DEPTH = 256;

   logic             clk = 1'b0;
   logic             res, req, wen, zero_ex;
   logic [15:0]      addr;
   op_enum_dmem_size mem_size;
   logic [31:0]      wr_data, rd_data;
   logic             ready, rsp_valid, err;

   always #5 clk = ~clk;

   dmem_responder #(
      .ADDR_WIDTH (16),
      .DEPTH      (DEPTH),
      .LATENCY    (LAT),
      .MEM_FILE   ("")
   ) dut (
      .clk       (clk),
      .res       (res),
      .req       (req),
      .wen       (wen),
      .addr      (addr),
      .mem_size  (mem_size),
      .zero_ex   (zero_ex),
      .wr_data   (wr_data),
      .ready     (ready),
      .rsp_valid (rsp_valid),
      .rd_data   (rd_data),
      .err       (err)
   );

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int unsigned cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          vectors = 0;
   int          miscompares = 0;
   int unsigned cyc = 0;
   int unsigned last_acc = 0;
   logic [7:0]  ref_mem [DEPTH];
   logic [31:0] last_rd = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: apply an access to the flat byte array, return expected rd_data/err.
   function automatic void ref_access(input bit w, input logic [15:0] a, input op_enum_dmem_size s,
                                      input bit z, input logic [31:0] d,
                                      output logic [31:0] rd, output logic e);
      int unsigned n;
      int unsigned ai;
      logic [31:0] v;
      ai = int'(a);
      case (s)
         SIZE_BYTE: n = 1;
         SIZE_HALF: n = 2;
         SIZE_WORD: n = 4;
         default:   n = 0;
      endcase
      e  = (n == 0) || (ai % n != 0) || (ai + n > DEPTH);
      rd = last_rd;
      if (w) begin
         if (!e) for (int unsigned k = 0; k < n; k++) ref_mem[ai + k] = d[8*k +: 8];
      end else if (e) begin
         rd = '0;
      end else begin
         v = '0;
         for (int unsigned k = 0; k < n; k++) v = v | (32'(ref_mem[ai + k]) << (8*k));
         if (n < 4 && !z && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
         rd = v;
      end
      last_rd = rd;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
      vectors++;
      if (act !== req_v) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", nm, act, req_v);
      end
   endtask

   // Holds req until accepted; fields may change while the DUT is busy.
   task automatic issue(input bit w, input logic [15:0] a, input op_enum_dmem_size s,
                        input bit z, input logic [31:0] d, input bit track);
      bit          held;
      int          n;
      exp_t        x;
      held     = req;
      wen      = w;
      addr     = a;
      mem_size = s;
      zero_ex  = z;
      wr_data  = d;
      req      = 1'b1;
      n        = 0;
      @(negedge clk);
      while (!ready && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (!ready) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: ready low for %0d cycles, required high", n);
         req = 1'b0;
         return;
      end
      if (held) check("held_req_accept_cycle", cyc, last_acc + LAT + 2);
      last_acc = cyc;
      if (track) begin
         ref_access(w, a, s, z, d, x.rd, x.err);
         x.cyc = cyc + LAT + 1;
         sb.push_back(x);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      req = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic op_enum_dmem_size rand_size();
      int unsigned r;
      r = $urandom_range(0, 15);
      if (r < 5)  return SIZE_BYTE;
      if (r < 10) return SIZE_HALF;
      if (r < 15) return SIZE_WORD;
      return op_enum_dmem_size'(2'b11);
   endfunction

   always @(negedge clk) begin
      if (!res) begin
         if (rsp_valid) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL spurious_rsp: rsp_valid high at cycle %0d, required low", cyc);
            end else begin
               mon_e = sb.pop_front();
               if (rd_data !== mon_e.rd || err !== mon_e.err || cyc != mon_e.cyc) begin
                  miscompares++;
                  $display("FAIL response: rd_data=%h err=%b cycle=%0d, required rd_data=%h err=%b cycle=%0d",
                           rd_data, err, cyc, mon_e.rd, mon_e.err, mon_e.cyc);
               end
            end
         end else if (err !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL err_idle: err=%b without rsp_valid, required 0", err);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      logic [15:0]      a;
      op_enum_dmem_size s;
      int unsigned      nb;
      int               n;

      res = 1'b1; req = 1'b0; wen = 1'b0; addr = '0;
      mem_size = SIZE_WORD; zero_ex = 1'b0; wr_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ready", 32'(ready), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rd_data", rd_data, 32'd0);
      check("reset_err", 32'(err), 32'd0);
      @(posedge clk);
      #1 res = 1'b0;

      for (int i = 0; i < DEPTH / 4; i++) issue(1, 16'(4 * i), SIZE_WORD, 0, $urandom, 1);
      idle(1);

      issue(1, 16'h0010, SIZE_WORD, 0, 32'hDEADBEEF, 1);
      idle(2);
      issue(0, 16'h0010, SIZE_WORD, 0, 32'h0, 1);
      issue(0, 16'h0013, SIZE_BYTE, 0, 32'h0, 1);
      issue(0, 16'h0013, SIZE_BYTE, 1, 32'h0, 1);
      issue(0, 16'h0010, SIZE_HALF, 0, 32'h0, 1);
      issue(1, 16'h0011, SIZE_BYTE, 0, 32'h12345677, 1);
      issue(0, 16'h0010, SIZE_WORD, 0, 32'h0, 1);
      issue(0, 16'h0012, SIZE_WORD, 0, 32'h0, 1);
      issue(0, 16'h0011, SIZE_HALF, 1, 32'h0, 1);
      issue(0, 16'h0100, SIZE_BYTE, 1, 32'h0, 1);
      issue(1, 16'h00FE, SIZE_WORD, 0, 32'h55AA55AA, 1);
      issue(0, 16'h0010, op_enum_dmem_size'(2'b11), 0, 32'h0, 1);
      issue(0, 16'h0010, SIZE_WORD, 0, 32'h0, 1);
      issue(0, 16'h00FF, SIZE_BYTE, 1, 32'h0, 1);
      idle(3);

      // Abort a store in its wait state; the array must keep the old word.
      issue(1, 16'h0020, SIZE_WORD, 0, 32'hCAFEF00D, 0);
      req = 1'b0;
      res = 1'b1;
      @(posedge clk);
      #1 res = 1'b0;
      last_rd = '0;
      @(negedge clk);
      check("ready_after_res", 32'(ready), 32'd1);
      check("rd_data_after_res", rd_data, 32'd0);
      idle(4);
      issue(0, 16'h0020, SIZE_WORD, 0, 32'h0, 1);
      issue(0, 16'h0022, SIZE_HALF, 0, 32'h0, 1);
      idle(1);

      for (int i = 0; i < 300; i++) begin
         s = rand_size();
         a = 16'($urandom_range(0, 16'h010F));
         case (s)
            SIZE_HALF: nb = 2;
            SIZE_WORD: nb = 4;
            default:   nb = 1;
         endcase
         if ($urandom_range(0, 3) != 0) a = a & ~16'(nb - 1);
         issue(1'($urandom_range(0, 1)), a, s, 1'($urandom_range(0, 1)), $urandom, 1);
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 3)));
      end

      req = 1'b0;
      n = 0;
      while (sb.size() > 0 && n < 20) begin
         n++;
         @(posedge clk);
      end
      @(negedge clk);
      if (sb.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
